uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Shares the single RS-232 transmit serializer between two byte requesters (e.g. the RX echo path and a status/message generator). Accepts one byte per request through a req/gnt handshake and issues a one-cycle start pulse with held data to the serializer. Waits for the serializer's frame-done pulse, or aborts on a timeout. Sits between the requesters and the TX serializer inside `top`, clocked at 100 MHz, 9600 baud.

## Interface
- `CLKS_PER_BIT`, 10416, serializer clocks per bit; used only for the timeout.
- `FRAME_BITS`, 10, bits per frame (start + 8 data + stop).
- `TIMEOUT`, `CLKS_PER_BIT*(FRAME_BITS+2)` = 124992, maximum cycles spent in SEND.
- `clk_i` input 1: system clock, single clock domain.
- `rst_i` input 1: asynchronous, active-high reset.
- `req_i` input 2: per-requester request, level, held with data until gnt.
- `data0_i` input 8: requester 0 byte.
- `data1_i` input 8: requester 1 byte.
- `gnt_o` output 2: one-hot, one-cycle pulse; the byte was captured.
- `tx_data_o` output 8: byte to serializer; stable from LOAD through the end of SEND.
- `tx_start_o` output 1: one-cycle start pulse to serializer.
- `tx_busy_i` input 1: serializer busy; blocks new grants while high.
- `tx_done_i` input 1: one-cycle pulse at the end of the stop bit.
- `busy_o` output 1: high whenever state ≠ IDLE.
- `src_o` output 1: index of the requester currently or last served.
- `timeout_o` output 1: one-cycle pulse when SEND exceeds TIMEOUT.

## Operation
- States: IDLE, LOAD, SEND.
- **IDLE**
  - If `req_i != 0` and `tx_busy_i == 0`, the arbiter picks winner w.
  - It captures `data{w}_i` into the `tx_data_o` register and sets `src_o` = w.
  - `gnt_o[w]` is driven high for the next cycle and the state moves to LOAD.
- **LOAD**
  - `tx_start_o` = 1 for exactly this cycle.
  - The timeout counter is cleared.
  - The state moves to SEND.
- **SEND**
  - The counter increments each cycle.
  - If `tx_done_i` is seen, the state moves to IDLE.
  - Else, if the counter reaches TIMEOUT-1, `timeout_o` pulses and the state moves to IDLE.
  - `tx_done_i` takes precedence over the timeout when both occur in the same cycle.
- `tx_done_i` is ignored in IDLE and LOAD.
- **Requester rules**
  - Keep `req_i[n]` and data stable until `gnt_o[n]` is seen high.
  - Deassert req in the gnt cycle, or keep it high to queue the next byte (the new data must be valid by then).
  - Dropping req before gnt withdraws the request; no side effects.
- Arbitration is per the Configuration section; a single requester always wins immediately.
- The timeout counter is 17 bits wide, saturates, and never wraps.
- Reset values: state IDLE, `gnt_o`=0, `tx_start_o`=0, `tx_data_o`=8'h00, `busy_o`=0, `src_o`=1, `timeout_o`=0, counter 0.
- A reset asserted mid-SEND returns the block to IDLE immediately. No done is awaited, and the serializer is not notified.

## Timing
- Request sampled at edge k → `gnt_o` high in cycle k..k+1 → `tx_start_o` high in cycle k+1..k+2.
- Request to start: 2 cycles.
- `tx_done_i` at cycle d → IDLE at d+1 → earliest next `gnt_o` at d+1..d+2, next `tx_start_o` one cycle later.
- With `tx_busy_i` still high after done, grants stall until it falls.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `UART_ARB_RR_EN` defined: round-robin.
  - On simultaneous requests, the requester ≠ `src_o` wins; after reset (`src_o`=1), requester 0 wins first.
  - Under continuous dual requests, grants alternate 0,1,0,1.
- `UART_ARB_RR_EN` undefined: fixed priority, requester 0 always beats requester 1.
  - `src_o` is still updated.
  - Requester 1 can starve.

## Test plan
- **Single request:** `req_i`=2'b01, `data0_i`=8'h3D → `gnt_o`=2'b01 one cycle later, `tx_start_o` the cycle after, `tx_data_o`=8'h3D held until `tx_done_i`; `busy_o` falls the next cycle.
- **Simultaneous requests:** `req_i`=2'b11 held, data 8'hA5/8'h5A, done modelled 104160 cycles after start.
  - RR build → bytes A5,5A,A5,5A in that order.
  - Non-RR build → A5 repeated, and `gnt_o[1]` is never asserted.
- **Timeout:** start issued and `tx_done_i` never pulsed → `timeout_o` pulses after TIMEOUT cycles in SEND, `busy_o`=0 the cycle after, and a pending req is then granted.
- **Busy stall:** `tx_busy_i`=1 with `req_i`=2'b10 → no `gnt_o` until `tx_busy_i` falls; `gnt_o`=2'b10 one cycle after it falls.
- **Reset mid-SEND:** assert `rst_i` 500 cycles after start → all outputs go to reset values asynchronously; after release, `req_i`=2'b11 grants requester 0 first.
- **Spurious done and withdrawal:**
  - `tx_done_i` pulsed in IDLE → no state change.
  - req raised then dropped while `tx_busy_i`=1 → no `gnt_o` and no `tx_start_o`.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Shares one UART transmit serializer between two byte
//               requesters. A byte is accepted through a req/gnt handshake,
//               held on tx_data_o, and launched with a one-cycle start pulse.
//               The block then waits for the serializer's frame-done pulse,
//               or gives up after TIMEOUT cycles.
//               Build option UART_ARB_RR_EN selects round-robin arbitration;
//               without it requester 0 has fixed priority over requester 1.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int FRAME_BITS   = 10,
    parameter int TIMEOUT      = CLKS_PER_BIT * (FRAME_BITS + 2)
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic [7:0] data0_i,
    input  logic [7:0] data1_i,
    output logic [1:0] gnt_o,
    output logic [7:0] tx_data_o,
    output logic       tx_start_o,
    input  logic       tx_busy_i,
    input  logic       tx_done_i,
    output logic       busy_o,
    output logic       src_o,
    output logic       timeout_o
);

    // Timeout counter width is fixed so the default TIMEOUT (124992) fits.
    localparam int                 c_CNT_W    = 17;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = {c_CNT_W{1'b1}};

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_LOAD = 2'd1;
    localparam logic [1:0] c_S_SEND = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               w_take;
    logic               w_timeout_hit;
    logic               w_win;
    logic [1:0]         r_gnt;
    logic [7:0]         r_data;
    logic               r_start;
    logic               r_busy;
    logic               r_src;
    logic               r_timeout;
    logic [c_CNT_W-1:0] r_cnt;

    // Pick the winning requester; only meaningful when some request is up.
    always_comb begin
        w_win = 1'b0;
`ifdef UART_ARB_RR_EN
        // Both requesting: the one not served last time goes next.
        if (req_i == 2'b11) begin
            w_win = ~r_src;
        end else begin
            w_win = req_i[1];
        end
`else
        // Requester 0 always wins when present.
        w_win = ~req_i[0];
`endif
    end

    // Next-state decision; grants only start from IDLE with the serializer free.
    always_comb begin
        w_state_nxt   = r_state;
        w_take        = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if ((req_i != 2'b00) && !tx_busy_i) begin
                    w_take      = 1'b1;
                    w_state_nxt = c_S_LOAD;
                end
            end
            c_S_LOAD: begin
                w_state_nxt = c_S_SEND;
            end
            c_S_SEND: begin
                // Frame completion beats the timeout when both land together.
                if (tx_done_i) begin
                    w_state_nxt = c_S_IDLE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_timeout_hit = 1'b1;
                    w_state_nxt   = c_S_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered handshake and status pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_gnt     <= 2'b00;
            r_start   <= 1'b0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_gnt     <= w_take ? (w_win ? 2'b10 : 2'b01) : 2'b00;
            r_start   <= (r_state == c_S_LOAD);
            r_busy    <= (w_state_nxt != c_S_IDLE);
            r_timeout <= w_timeout_hit;
        end
    end

    // Capture the winning byte and its source; held until the next grant.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_data <= 8'h00;
            r_src  <= 1'b1;
        end else if (w_take) begin
            r_data <= w_win ? data1_i : data0_i;
            r_src  <= w_win;
        end
    end

    // SEND-phase cycle counter: cleared in LOAD, saturating count in SEND.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (r_state == c_S_LOAD) begin
            r_cnt <= '0;
        end else if ((r_state == c_S_SEND) && (r_cnt != c_CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign gnt_o      = r_gnt;
    assign tx_data_o  = r_data;
    assign tx_start_o = r_start;
    assign busy_o     = r_busy;
    assign src_o      = r_src;
    assign timeout_o  = r_timeout;

endmodule
`default_nettype wire
